generador_estimulos: RTL
========================

GENERADOR_ESTIMULOS -- requirements
Module: generador_estimulos

Interface
REQ-001 SHALL have parameter WIDTH, default 8: pattern length in bits.
REQ-002 SHALL have parameter HOLD_W, default 4: width of the per-bit hold field.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request to transmit one pattern.
REQ-006 SHALL have port patron, input, WIDTH bits: pattern to send, MSB first.
REQ-007 SHALL have port hold, input, HOLD_W bits: each bit is driven for hold+1 cycles.
REQ-008 SHALL have port y, input, 1 bit: response from the FSM under test.
REQ-009 SHALL have port a, output, 1 bit: serial stimulus to the FSM under test.
REQ-010 SHALL have port busy, output, 1 bit: high while the pattern is being driven.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse after the last bit.
REQ-012 SHALL have port y_count, output, 8 bits: count of SHIFT cycles with y=1, saturating.

Function
REQ-013 SHALL implement an FSM with states IDLE, SHIFT and FIN; a, busy and done SHALL be registered.
REQ-014 IDLE behaviour:
- a=0, busy=0.
- start=1 at edge k latches patron and hold, clears y_count, loads the bit index with WIDTH-1 and the hold counter with hold, and enters SHIFT.
REQ-015 SHIFT behaviour:
- From cycle k+1, a = current latched MSB and busy=1.
- The hold counter decrements each cycle.
- At zero, the register shifts left and the counter reloads, or the block goes to FIN if the index is 0.
- Total SHIFT time is exactly WIDTH*(hold+1) cycles.
REQ-016 FIN behaviour: lasts one cycle with done=1, busy=0, a=0, then returns to IDLE unconditionally.
REQ-017 start SHALL be ignored in SHIFT and FIN; patron/hold changes after latching SHALL NOT affect the transfer in progress.
REQ-018 y SHALL be sampled on every SHIFT cycle edge:
- y_count increments when y=1.
- y_count saturates at 255 with no wrap.
- y_count holds its value through FIN and IDLE until the next accepted start.
REQ-019 hold=0 SHALL give one cycle per bit; hold=2^HOLD_W-1 SHALL give 2^HOLD_W cycles per bit with no counter overflow.
REQ-020 start held high continuously SHALL produce back-to-back transfers separated by exactly one FIN cycle plus one IDLE cycle.

Reset
REQ-021 reset=0 SHALL immediately, without waiting for clk, force:
- state=IDLE;
- a=0, busy=0, done=0, y_count=0;
- shift register, index and hold counter to 0.
REQ-022 Reset asserted mid-SHIFT SHALL abort the transfer with no done pulse.
REQ-023 After reset release, the first start SHALL be honoured on the first rising edge at which reset=1.

Configuration
REQ-024 Macro GEN_Y_COUNT_EN:
- When defined, y sampling and y_count SHALL behave as in REQ-018.
- When undefined, the counter logic SHALL be absent, y SHALL be unused and y_count SHALL be tied to 0.
- a, busy and done timing SHALL be identical in both cases.

Verification
REQ-025 One cycle per bit:
- Stimulus: patron=8'b1010_0000, hold=0, start pulse at edge k.
- Required: a = 1,0,1,0,0,0,0,0 on cycles k+1..k+8; busy=1 exactly on those cycles; done=1 only on k+9.
REQ-026 Held bits with y looped back:
- Stimulus: patron=8'hFF, hold=3, y tied to a (macro defined).
- Required: a=1 for 32 cycles; y_count=32 at done.
- Repeat with patron=8'h0F: y_count=16.
REQ-027 start while busy:
- Stimulus: start with patron=8'hF0, then start=1 with patron=8'h0F during SHIFT.
- Required: a follows 8'hF0 only; exactly one done pulse.
REQ-028 Reset mid-transfer:
- Stimulus: reset=0 at cycle 5 of SHIFT, asynchronously between edges.
- Required: a, busy and y_count drop to 0 before the next edge; no done pulse; a new start after release transmits normally.
REQ-029 Saturation:
- Stimulus: WIDTH=16, hold=15, y=1 constant.
- Required: 256 SHIFT cycles; y_count=255 at done, with no wrap.
REQ-030 Macro undefined:
- Stimulus: same as REQ-026.
- Required: identical a/busy/done waveforms; y_count=0 throughout.

Source files
------------

// File: rtl/generador_estimulos.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : generador_estimulos                                        |
// | Description : Serial stimulus generator for an FSM under test. Sends a   |
// |               latched pattern MSB first, each bit held for hold+1        |
// |               cycles, and counts the SHIFT cycles on which the response  |
// |               y is high (saturating 8-bit counter).                      |
// | Options     : GEN_Y_COUNT_EN - when defined, builds the y_count logic;   |
// |               when undefined, y is unused and y_count is tied to 0.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module generador_estimulos #(
   parameter int WIDTH  = 8,
   parameter int HOLD_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [WIDTH-1:0]  patron,
   input  logic [HOLD_W-1:0] hold,
   input  logic              y,
   output logic              a,
   output logic              busy,
   output logic              done,
   output logic [7:0]        y_count
);

   localparam int                 C_IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [C_IDX_W-1:0] C_IDX_LAST = C_IDX_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FIN   = 2'd2
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [WIDTH-1:0]    r_sh, w_sh_nxt, w_sh_shl;
   logic [C_IDX_W-1:0]  r_idx, w_idx_nxt;
   logic [HOLD_W-1:0]   r_hold, w_hold_nxt;
   logic [HOLD_W-1:0]   r_cnt, w_cnt_nxt;
   logic                r_a, w_a_nxt;
   logic                r_busy, w_busy_nxt;
   logic                r_done, w_done_nxt;

   assign w_sh_shl = r_sh << 1;

   // State, datapath and registered outputs; reset clears everything at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_sh    <= '0;
         r_idx   <= '0;
         r_hold  <= '0;
         r_cnt   <= '0;
         r_a     <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_sh    <= w_sh_nxt;
         r_idx   <= w_idx_nxt;
         r_hold  <= w_hold_nxt;
         r_cnt   <= w_cnt_nxt;
         r_a     <= w_a_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Next state and next output values; outputs are computed one cycle ahead
   // so that a/busy/done come straight from flops.
   always_comb begin
      w_state_nxt = r_state;
      w_sh_nxt    = r_sh;
      w_idx_nxt   = r_idx;
      w_hold_nxt  = r_hold;
      w_cnt_nxt   = r_cnt;
      w_a_nxt     = 1'b0;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = SHIFT;
               w_sh_nxt    = patron;
               w_hold_nxt  = hold;
               w_cnt_nxt   = hold;
               w_idx_nxt   = C_IDX_LAST;
               w_a_nxt     = patron[WIDTH-1];
               w_busy_nxt  = 1'b1;
            end
         end
         SHIFT: begin
            w_busy_nxt = 1'b1;
            w_a_nxt    = r_sh[WIDTH-1];
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - HOLD_W'(1);
            end else if (r_idx == '0) begin
               // Last cycle of the last bit: one-cycle FIN with done high.
               w_state_nxt = FIN;
               w_a_nxt     = 1'b0;
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
            end else begin
               w_sh_nxt  = w_sh_shl;
               w_cnt_nxt = r_hold;
               w_idx_nxt = r_idx - C_IDX_W'(1);
               w_a_nxt   = w_sh_shl[WIDTH-1];
            end
         end
         FIN: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign a    = r_a;
   assign busy = r_busy;
   assign done = r_done;

`ifdef GEN_Y_COUNT_EN
   logic [7:0] r_ycnt;

   // Count SHIFT-cycle edges with y high; cleared by an accepted start and
   // held through FIN/IDLE, saturating at 255.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ycnt <= 8'd0;
      end else if ((r_state == IDLE) && start) begin
         r_ycnt <= 8'd0;
      end else if ((r_state == SHIFT) && y && (r_ycnt != 8'hFF)) begin
         r_ycnt <= r_ycnt + 8'd1;
      end
   end

   assign y_count = r_ycnt;
`else
   logic w_unused_y;

   assign w_unused_y = y;
   assign y_count    = 8'd0;
`endif

endmodule
`default_nettype wire
